e203_exu_flush_arb: RTL and testbench
=====================================

Name: e203_exu_flush_arb

Overview:
- Central pipeline-flush arbiter/sequencer in the EXU commit stage.
- Takes flush requests from two requesters: the exception/interrupt/debug-entry trap path ("excp") and the branch-mispredict resolve path ("bjp").
- Picks one winner, registers its target operands and drives one stable flush request to the IFU until the IFU acknowledges. It then holds a short drain window before granting the next flush.
- Gives each requester a per-request acknowledge and keeps a saturating count of completed flushes.

Parameters:
- PC_W, 32, width of PC / flush target operands (matches E203_PC_SIZE).
- DRAIN_CYC, 2, number of post-ack cycles during which no new flush is granted. Legal range 0..15.
- CNT_W, 8, width of the completed-flush counter.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- excp_flush_req  in  1  trap-path flush request. Held high until excp_flush_ack.
- excp_flush_add_op1  in  PC_W  trap target operand 1 (vector base / debug ROM address).
- excp_flush_add_op2  in  PC_W  trap target operand 2.
- excp_flush_ack  out  1  one-cycle ack of a completed trap flush.
- bjp_flush_req  in  1  branch-mispredict flush request.
- bjp_flush_add_op1  in  PC_W  branch target operand 1.
- bjp_flush_add_op2  in  PC_W  branch target operand 2.
- bjp_flush_ack  out  1  one-cycle ack of a completed branch flush.
- pipe_flush_req  out  1  flush request to the IFU.
- pipe_flush_add_op1  out  PC_W  registered target operand 1 to the IFU.
- pipe_flush_add_op2  out  PC_W  registered target operand 2 to the IFU.
- pipe_flush_src  out  1  source of the current flush: 1 = excp, 0 = bjp.
- pipe_flush_ack  in  1  IFU accepts the flush.
- flush_busy  out  1  high in any state other than IDLE.
- cnt_clr  in  1  synchronous clear of flush_cnt.
- flush_cnt  out  CNT_W  completed flushes, saturating.

Behaviour:
- FSM states: IDLE, REQ, DRAIN. State is one registered field; all transitions happen on the rising edge of clk.
- Reset (rst_n=0 at an edge), including in the middle of a flush:
  - State goes to IDLE.
  - Latched operands, pipe_flush_src and the drain counter clear to 0.
  - flush_cnt clears to 0.
  - All outputs read 0 the cycle after reset, including pipe_flush_req, both acks and flush_busy.
  - An in-flight flush is abandoned and no ack is issued for it.
- IDLE:
  - If excp_flush_req or bjp_flush_req is high: latch the winner's op1/op2, set pipe_flush_src, go to REQ.
  - Priority is fixed: excp over bjp.
  - Grant latency: 1 cycle (request at edge N gives pipe_flush_req=1 from cycle N+1).
- REQ:
  - pipe_flush_req=1. Operands and src stay stable until the handshake; input operand changes are ignored.
  - When pipe_flush_ack=1, the handshake completes that cycle:
    - The winner's ack (excp_flush_ack or bjp_flush_ack) is driven combinationally high in that same cycle, exactly one cycle long.
    - flush_cnt increments.
    - Next state is DRAIN with the drain counter loaded to DRAIN_CYC-1, or IDLE if DRAIN_CYC=0.
  - A granted flush is never preempted. An excp request arriving while a bjp flush is in REQ waits, and pipe_flush_src does not change.
  - A request dropped after grant does not cancel the flush; the ack is still issued.
- DRAIN:
  - pipe_flush_req=0, flush_busy=1, no grants.
  - The drain counter decrements each cycle. When it is 0, go to IDLE.
  - Requests presented during DRAIN are granted in the first IDLE cycle, with normal priority.
- Simultaneous requests:
  - excp wins and bjp is not acked. bjp may keep requesting and is served after the drain.
  - Upstream normally withdraws bjp when a trap kills the branch; the arbiter does not require this.
- Back-to-back throughput: one flush per 2+DRAIN_CYC cycles minimum, given an immediate ack.
- flush_cnt:
  - Increments by 1 on each handshake and saturates at all-ones.
  - cnt_clr has priority over increment; if both occur in the same cycle, the result is 0.
- pipe_flush_ack outside REQ is ignored.
- excp_flush_ack and bjp_flush_ack are never high in the same cycle.

Test Plan:
- Single bjp flush: bjp_flush_req=1 with ops 0x8000_0100/0x4 at cycle 0. Expect pipe_flush_req=1 from cycle 1 with ops 0x8000_0100/0x4 and src=0. Ack at cycle 3 → bjp_flush_ack=1 in cycle 3 only, flush_cnt=1, busy through cycle 5, IDLE at cycle 6.
- Simultaneous requests: excp (0x0000_0080/0) and bjp asserted at cycle 0, immediate ack. Expect excp served first (src=1, excp_flush_ack in cycle 1). bjp granted in the first IDLE cycle after the drain, with src=0. flush_cnt=2.
- No preemption: bjp in REQ, excp rises, IFU delays ack 5 cycles. Expect operands/src unchanged throughout, bjp acked, then excp served after the drain.
- Stall hold: in REQ, change bjp ops every cycle while pipe_flush_ack=0. Expect pipe_flush_add_op1/op2 frozen at the latched values.
- Saturation/clear: CNT_W=2, four flushes → flush_cnt=3. cnt_clr in the same cycle as a handshake → flush_cnt=0.
- Reset mid-flush: rst_n=0 during REQ → next cycle all outputs 0 and state IDLE, no ack issued. A request after reset is granted with 1-cycle latency. DRAIN_CYC=0 build: ack leads directly to IDLE.

Source files
------------

// File: rtl/e203_exu_flush_arb.sv
// Commit-stage flush arbiter: grants one of the trap / branch flush requests,
// holds a stable flush request to the IFU until it is accepted, then drains.
module e203_exu_flush_arb #(
    parameter int PC_W      = 32,
    parameter int DRAIN_CYC = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             excp_flush_req,
    input  logic [PC_W-1:0]  excp_flush_add_op1,
    input  logic [PC_W-1:0]  excp_flush_add_op2,
    output logic             excp_flush_ack,

    input  logic             bjp_flush_req,
    input  logic [PC_W-1:0]  bjp_flush_add_op1,
    input  logic [PC_W-1:0]  bjp_flush_add_op2,
    output logic             bjp_flush_ack,

    output logic             pipe_flush_req,
    output logic [PC_W-1:0]  pipe_flush_add_op1,
    output logic [PC_W-1:0]  pipe_flush_add_op2,
    output logic             pipe_flush_src,
    input  logic             pipe_flush_ack,

    output logic             flush_busy,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // The drain counter holds DRAIN_CYC-1 so that DRAIN lasts exactly DRAIN_CYC cycles.
    localparam int              DRAIN_LOAD_I = (DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0;
    localparam logic [3:0]      DRAIN_LOAD   = DRAIN_LOAD_I[3:0];
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [3:0]        drain_q, drain_d;
    logic [PC_W-1:0]   op1_q, op1_d;
    logic [PC_W-1:0]   op2_q, op2_d;
    logic              src_q, src_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hs;

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        src_d   = src_q;
        hs      = 1'b0;

        case (state_q)
            IDLE: begin
                if (excp_flush_req) begin
                    op1_d   = excp_flush_add_op1;
                    op2_d   = excp_flush_add_op2;
                    src_d   = 1'b1;
                    state_d = REQ;
                end else if (bjp_flush_req) begin
                    op1_d   = bjp_flush_add_op1;
                    op2_d   = bjp_flush_add_op2;
                    src_d   = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // Operands and source are frozen here; only the IFU ack moves us on.
                if (pipe_flush_ack) begin
                    hs = 1'b1;
                    if (DRAIN_CYC == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                        drain_d = DRAIN_LOAD;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Clear wins over a coincident handshake; the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (hs && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            drain_q <= 4'd0;
            op1_q   <= '0;
            op2_q   <= '0;
            src_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
        end
    end

    // A handshake coinciding with reset is abandoned, so the acks are gated by rst_n.
    assign excp_flush_ack     = hs & rst_n & src_q;
    assign bjp_flush_ack      = hs & rst_n & ~src_q;
    assign pipe_flush_req     = (state_q == REQ);
    assign pipe_flush_add_op1 = op1_q;
    assign pipe_flush_add_op2 = op2_q;
    assign pipe_flush_src     = src_q;
    assign flush_busy         = (state_q != IDLE);
    assign flush_cnt          = cnt_q;

endmodule

// File: tb/tb_e203_exu_flush_arb.sv
// Randomized bench for e203_exu_flush_arb: two builds (DRAIN_CYC=2/CNT_W=3 and
// DRAIN_CYC=0/CNT_W=2) each checked against a timeline model and a flush scoreboard.
module tb_e203_exu_flush_arb;

    localparam int NCYC = 4000;

    typedef struct {
        bit          src;
        logic [31:0] op1;
        logic [31:0] op2;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    bit done [2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int DC   = (g == 0) ? 2 : 0;
        localparam int CW   = (g == 0) ? 3 : 2;
        localparam int CMAX = (1 << CW) - 1;

        logic          rst_n = 1'b0;
        logic          excp_req = 1'b0, bjp_req = 1'b0;
        logic [31:0]   excp_op1 = '0, excp_op2 = '0, bjp_op1 = '0, bjp_op2 = '0;
        logic          excp_ack, bjp_ack;
        logic          pf_req, pf_src, pf_busy;
        logic [31:0]   pf_op1, pf_op2;
        logic          pf_ack = 1'b0;
        logic          cnt_clr = 1'b0;
        logic [CW-1:0] fcnt;
        bit            started = 1'b0;

        e203_exu_flush_arb #(.PC_W(32), .DRAIN_CYC(DC), .CNT_W(CW)) dut (
            .clk                (clk),
            .rst_n              (rst_n),
            .excp_flush_req     (excp_req),
            .excp_flush_add_op1 (excp_op1),
            .excp_flush_add_op2 (excp_op2),
            .excp_flush_ack     (excp_ack),
            .bjp_flush_req      (bjp_req),
            .bjp_flush_add_op1  (bjp_op1),
            .bjp_flush_add_op2  (bjp_op2),
            .bjp_flush_ack      (bjp_ack),
            .pipe_flush_req     (pf_req),
            .pipe_flush_add_op1 (pf_op1),
            .pipe_flush_add_op2 (pf_op2),
            .pipe_flush_src     (pf_src),
            .pipe_flush_ack     (pf_ack),
            .flush_busy         (pf_busy),
            .cnt_clr            (cnt_clr),
            .flush_cnt          (fcnt)
        );

        // Reference model: an owned flush (m_has), a quiet window measured in
        // cycles, and a plain integer count clamped at CMAX.
        bit          m_has   = 1'b0;
        int          m_quiet = 0;
        int          m_cnt   = 0;
        bit          m_src   = 1'b0;
        logic [31:0] m_op1   = '0;
        logic [31:0] m_op2   = '0;
        txn_t        sbq[$];

        always @(posedge clk) begin
            if (!rst_n) begin
                m_has = 0; m_quiet = 0; m_cnt = 0;
                m_src = 0; m_op1 = '0; m_op2 = '0;
                sbq.delete();
            end else begin
                if (m_has && pf_ack) begin
                    m_has   = 0;
                    m_quiet = DC;
                    m_cnt   = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
                end else if (!m_has && m_quiet > 0) begin
                    m_quiet = m_quiet - 1;
                end else if (!m_has && (excp_req || bjp_req)) begin
                    txn_t t;
                    t.src = excp_req;
                    t.op1 = excp_req ? excp_op1 : bjp_op1;
                    t.op2 = excp_req ? excp_op2 : bjp_op2;
                    m_has = 1; m_src = t.src; m_op1 = t.op1; m_op2 = t.op2;
                    sbq.push_back(t);
                end
                if (cnt_clr) m_cnt = 0;
            end
        end

        // Monitor: per-cycle output checks plus scoreboard pop on each IFU handshake.
        always @(negedge clk) begin
            if (started) begin
                bit exp_hs;
                exp_hs = m_has && pf_ack && rst_n;
                chk($sformatf("g%0d.pipe_flush_req", g), 64'(pf_req), 64'(m_has));
                chk($sformatf("g%0d.flush_busy", g), 64'(pf_busy), 64'(m_has || m_quiet > 0));
                chk($sformatf("g%0d.pipe_flush_src", g), 64'(pf_src), 64'(m_src));
                chk($sformatf("g%0d.op1", g), 64'(pf_op1), 64'(m_op1));
                chk($sformatf("g%0d.op2", g), 64'(pf_op2), 64'(m_op2));
                chk($sformatf("g%0d.excp_ack", g), 64'(excp_ack), 64'(exp_hs && m_src));
                chk($sformatf("g%0d.bjp_ack", g), 64'(bjp_ack), 64'(exp_hs && !m_src));
                chk($sformatf("g%0d.flush_cnt", g), 64'(fcnt), 64'(m_cnt));
                if (pf_req === 1'b1) begin
                    if (sbq.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL g%0d.sb_unexpected: got pipe_flush_req=1 expected no flush at %0t", g, $time);
                    end else begin
                        chk($sformatf("g%0d.sb_src", g), 64'(pf_src), 64'(sbq[0].src));
                        chk($sformatf("g%0d.sb_op1", g), 64'(pf_op1), 64'(sbq[0].op1));
                        chk($sformatf("g%0d.sb_op2", g), 64'(pf_op2), 64'(sbq[0].op2));
                        if (pf_ack && rst_n) void'(sbq.pop_front());
                    end
                end
            end
        end

        // Requesters hold until acked (bjp occasionally withdraws); IFU acks randomly.
        initial begin
            bit got_e, got_b;
            rst_n = 1'b0;
            @(posedge clk);
            started = 1'b1;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            for (int i = 0; i < NCYC; i++) begin
                @(negedge clk);
                got_e = excp_ack;
                got_b = bjp_ack;
                @(posedge clk);
                #1;
                rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
                if (got_e)                                excp_req = 1'b0;
                else if (!excp_req && $urandom_range(0, 99) < 15) excp_req = 1'b1;
                if (got_b)                                bjp_req = 1'b0;
                else if (bjp_req && $urandom_range(0, 99) < 3)    bjp_req = 1'b0;
                else if (!bjp_req && $urandom_range(0, 99) < 25)  bjp_req = 1'b1;
                if (excp_req) begin excp_op1 = $urandom; excp_op2 = $urandom; end
                if (bjp_req)  begin bjp_op1  = $urandom; bjp_op2  = $urandom; end
                pf_ack  = rst_n && ($urandom_range(0, 99) < 40);
                cnt_clr = ($urandom_range(0, 99) < 4);
            end
            done[g] = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 3 * NCYC; i++) begin
            if (done[0] && done[1]) break;
            @(posedge clk);
        end
        if (!(done[0] && done[1])) begin
            miscompares++;
            $display("FAIL timeout: got unfinished stimulus expected completion");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
